// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit owning HI/LO; 34-cycle busy window per op.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV (abs in PREP, sign fix in FIN).
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIN} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_cnt;
  logic             r_isDiv;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_rawA;
  logic [WIDTH-1:0] r_rawB;
  logic [WIDTH-1:0] r_upper;
  logic [WIDTH-1:0] r_lower;
  logic [WIDTH-1:0] r_opd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH-1:0] w_finHi;
  logic [WIDTH-1:0] w_finLo;
  logic [WIDTH:0]   w_addA;
  logic [WIDTH:0]   w_addB;
  logic [WIDTH:0]   w_sum;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = PREP;
      PREP:    w_nextState = RUN;
      RUN:     if (r_cnt == CW'(WIDTH - 1)) w_nextState = FIN;
      FIN:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

`ifdef MULDIV_SIGNED_EN
  logic                 r_signedOp;
  logic                 r_negLo;
  logic                 r_negHi;
  logic                 w_negA;
  logic                 w_negB;
  logic [2*WIDTH-1:0]   w_prodNeg;

  assign w_negA    = r_signedOp & r_rawA[WIDTH-1];
  assign w_negB    = r_signedOp & r_rawB[WIDTH-1];
  assign w_absA    = w_negA ? -r_rawA : r_rawA;
  assign w_absB    = w_negB ? -r_rawB : r_rawB;
  assign w_prodNeg = -{r_upper, r_lower};

  // Multiply negates the whole product; divide fixes quotient and remainder separately.
  always_comb begin
    w_finHi = r_upper;
    w_finLo = r_lower;
    if (r_isDiv) begin
      if (r_negLo) w_finLo = -r_lower;
      if (r_negHi) w_finHi = -r_upper;
    end else if (r_negLo) begin
      w_finHi = w_prodNeg[2*WIDTH-1:WIDTH];
      w_finLo = w_prodNeg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_signedOp <= 1'b0;
      r_negLo    <= 1'b0;
      r_negHi    <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_signedOp <= op[0];
    end else if (r_state == PREP) begin
      r_negLo <= w_negA ^ w_negB;
      r_negHi <= r_isDiv ? w_negA : (w_negA ^ w_negB);
    end
  end
`else
  logic w_unusedOp0;

  assign w_unusedOp0 = op[0];
  assign w_absA      = r_rawA;
  assign w_absB      = r_rawB;
  assign w_finHi     = r_upper;
  assign w_finLo     = r_lower;
`endif

  // Shared adder: multiply adds the multiplicand into the upper half,
  // divide subtracts the divisor from the left-shifted remainder.
  assign w_addA = r_isDiv ? {r_upper, r_lower[WIDTH-1]} : {1'b0, r_upper};
  assign w_addB = r_isDiv ? ~{1'b0, r_opd} : (r_lower[0] ? {1'b0, r_opd} : '0);
  assign w_sum  = w_addA + w_addB + {{WIDTH{1'b0}}, r_isDiv};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_isDiv <= 1'b0;
      r_rawA  <= '0;
      r_rawB  <= '0;
      r_upper <= '0;
      r_lower <= '0;
      r_opd   <= '0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_nextState != IDLE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rawA  <= inA;
            r_rawB  <= inB;
            r_isDiv <= op[1];
            r_dbz   <= 1'b0;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        PREP: begin
          r_upper <= '0;
          r_cnt   <= '0;
          if (r_isDiv) begin
            r_lower <= w_absA;
            r_opd   <= w_absB;
          end else begin
            r_lower <= w_absB;
            r_opd   <= w_absA;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_isDiv) begin
            r_upper <= w_sum[WIDTH] ? w_addA[WIDTH-1:0] : w_sum[WIDTH-1:0];
            r_lower <= {r_lower[WIDTH-2:0], ~w_sum[WIDTH]};
          end else begin
            r_upper <= w_sum[WIDTH:1];
            r_lower <= {w_sum[0], r_lower[WIDTH-1:1]};
          end
        end
        FIN: begin
          r_done <= 1'b1;
          if (r_isDiv && r_rawB == '0) begin
            r_hi  <= r_rawA;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else begin
            r_hi <= w_finHi;
            r_lo <= w_finLo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO queued at start, compared on done.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] inA = '0;
  logic [31:0] inB = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sbQ[$];
  int   errCount = 0;
  int   checkCount = 0;
  int   cycleCnt = 0;
  int   startEdge = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model of the architectural result, independent of the iteration scheme.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic        signedOp;
    logic [63:0] p;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
`ifdef MULDIV_SIGNED_EN
    signedOp = o[0];
`else
    signedOp = 1'b0;
`endif
    e.dbz = 1'b0;
    if (!o[1]) begin
      if (signedOp) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      else          p = {32'b0, a} * {32'b0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else if (signedOp) begin
      sa   = $signed(a);
      sb   = $signed(b);
      q    = sa / sb;
      r    = sa % sb;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDone", 1, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("hi", hi, e.hi);
        checkOutput("lo", lo, e.lo);
        checkOutput("divByZero", div_by_zero, e.dbz);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge E0.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input bit expectDone, input bit withMtlo, input logic [31:0] mtData);
    int guard = 0;
    while (busy === 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy !== 1'b0) checkOutput("idleWait", busy, 0);
    start = 1'b1;
    op    = o;
    inA   = a;
    inB   = b;
    if (withMtlo) begin
      mtlo  = 1'b1;
      wdata = mtData;
    end
    if (expectDone) sbQ.push_back(model(o, a, b));
    @(posedge clk);
    #1;
    startEdge = cycleCnt;
    checkOutput("busyAtStart", busy, 1);
    checkOutput("dbzCleared", div_by_zero, 0);
    @(negedge clk);
    start = 1'b0;
    mtlo  = 1'b0;
  endtask

  task automatic waitDone(input bit pulseCheck);
    int guard = 0;
    int busyLow = 0;
    while (done !== 1'b1 && guard < 100) begin
      if (busy !== 1'b1) busyLow++;
      @(negedge clk);
      guard++;
    end
    if (done !== 1'b1) begin
      checkOutput("doneTimeout", 0, 1);
    end else begin
      checkOutput("latency", cycleCnt - startEdge, 34);
      checkOutput("busyHeld", busyLow, 0);
      checkOutput("busyFall", busy, 0);
      if (pulseCheck) begin
        @(negedge clk);
        checkOutput("donePulse", done, 0);
      end
    end
  endtask

  initial begin
    logic [1:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;

    repeat (3) @(negedge clk);
    checkOutput("rstHi", hi, 0);
    checkOutput("rstLo", lo, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstDbz", div_by_zero, 0);
    reset = 1'b0;
    @(negedge clk);

    // Second op is issued the cycle done appears, i.e. accepted at E0+35.
    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0);
    waitDone(0);
    applyStimulus(2'd1, 32'hFFFF_FFFD, 32'd7, 1, 0, 0);
    waitDone(1);
    applyStimulus(2'd3, 32'hFFFF_FFF9, 32'd2, 1, 0, 0);
    waitDone(1);
    applyStimulus(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0);
    waitDone(1);
    applyStimulus(2'd2, 32'd100, 32'd0, 1, 0, 0);
    waitDone(1);

    // Start, MTHI and MTLO while busy must all be ignored.
    applyStimulus(2'd2, 32'd100, 32'd7, 1, 0, 0);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd0; inA = 32'd2; inB = 32'd3;
    mthi = 1'b1; wdata = 32'hAAAA_0000;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b1; wdata = 32'h0000_5555;
    @(negedge clk);
    mtlo = 1'b0;
    checkOutput("busyMthiIgnored", hi, 32'h0000_0064);
    checkOutput("busyMtloIgnored", lo, 32'hFFFF_FFFF);
    waitDone(1);
    repeat (40) @(negedge clk);
    checkOutput("noQueuedStart", busy, 0);

    // Reset sampled at E0+10 aborts the multiply with no done pulse.
    applyStimulus(2'd0, 32'd5, 32'd6, 0, 0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortHi", hi, 0);
    checkOutput("abortLo", lo, 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_CAFE;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    checkOutput("mtBothHi", hi, 32'h0000_CAFE);
    checkOutput("mtBothLo", lo, 32'h0000_CAFE);
    mthi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    checkOutput("mthi", hi, 32'h1234_5678);
    mtlo = 1'b1; wdata = 32'h0000_0009;
    @(negedge clk);
    mtlo = 1'b0;
    checkOutput("mtlo", lo, 32'h0000_0009);
    checkOutput("mtloKeepsHi", hi, 32'h1234_5678);
    applyStimulus(2'd0, 32'd3, 32'd4, 1, 1, 32'h0000_DEAD);
    checkOutput("mtloDropped", lo, 32'h0000_0009);
    waitDone(1);

    for (int i = 0; i < 8; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA  = $urandom;
      rB  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      applyStimulus(rOp, rA, rB, 1, 0, 0);
      waitDone(1);
    end

    repeat (3) @(negedge clk);
    checkOutput("sbEmpty", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
